// File: rtl/sys_bridge_pkg.sv
// Shared encodings for the data-side system bus: access ops, exception codes,
// address map and timer register/state layout.
package sys_bridge_pkg;

    // Store op encodings (Mem_SOp)
    localparam logic [2:0] SOP_NONE = 3'd0;
    localparam logic [2:0] SOP_SW   = 3'd1;
    localparam logic [2:0] SOP_SH   = 3'd2;
    localparam logic [2:0] SOP_SB   = 3'd3;

    // Load op encodings (Mem_LOp)
    localparam logic [2:0] LOP_NONE = 3'd0;
    localparam logic [2:0] LOP_LW   = 3'd1;
    localparam logic [2:0] LOP_LH   = 3'd2;
    localparam logic [2:0] LOP_LHU  = 3'd3;
    localparam logic [2:0] LOP_LB   = 3'd4;
    localparam logic [2:0] LOP_LBU  = 3'd5;

    // Exception codes reported on Mem_EC
    localparam logic [4:0] ERR_NONE = 5'd0;
    localparam logic [4:0] ERR_ADEL = 5'd4;
    localparam logic [4:0] ERR_ADES = 5'd5;

    // Default address map
    localparam int          DM_WORDS_DEF = 3072;
    localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;
    localparam logic [31:0] IG_BASE_DEF  = 32'h0000_7F20;

    // Timer register select (address bits [3:2])
    localparam logic [1:0] TREG_CTRL   = 2'd0;
    localparam logic [1:0] TREG_PRESET = 2'd1;
    localparam logic [1:0] TREG_COUNT  = 2'd2;

    // Timer mode field: only mode 1 auto-reloads, everything else is one-shot
    localparam logic [1:0] TMODE_AUTO = 2'd1;

    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_LOAD = 2'd1,
        TS_CNT  = 2'd2,
        TS_INT  = 2'd3
    } timer_state_e;

    // CTRL register layout, bit 3 down to bit 0
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } timer_ctrl_t;

    // True when addr falls in the 12-byte register window of a timer
    function automatic logic in_timer(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && (addr <= base + 32'hB);
    endfunction

endpackage

// File: rtl/sys_bridge_timer_dev.sv
// Down-counting timer with CTRL/PRESET/COUNT registers, one-shot or auto-reload,
// and a maskable interrupt output.
module timer_dev
    import sys_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    timer_state_e state_q,  state_d;
    timer_ctrl_t  ctrl_q,   ctrl_d;
    logic [31:0]  preset_q, preset_d;
    logic [31:0]  count_q,  count_d;
    logic         irq_q,    irq_d;

    // Next-state: FSM advance first, then a CPU write overrides the register it targets
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = (ctrl_q.mode == TMODE_AUTO) ? 1'b0 : irq_q;

        unique case (state_q)
            TS_IDLE: begin
                if (ctrl_q.en) state_d = TS_LOAD;
            end
            TS_LOAD: begin
                count_d = preset_q;
                state_d = TS_CNT;
            end
            TS_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = TS_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    state_d = TS_INT;
                end
            end
            TS_INT: begin
                irq_d = ctrl_q.im;
                if (ctrl_q.mode == TMODE_AUTO) begin
                    state_d = TS_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = TS_IDLE;
                end
            end
            default: state_d = TS_IDLE;
        endcase

        if (we) begin
            unique case (addr)
                TREG_CTRL: begin
                    ctrl_d = timer_ctrl_t'(wdata[3:0]);
                    irq_d  = 1'b0;
                end
                TREG_PRESET: begin
                    preset_d = wdata;
                    irq_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            state_q  <= TS_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Register read mux
    always_comb begin
        unique case (addr)
            TREG_CTRL:   rdata = {28'b0, ctrl_q};
            TREG_PRESET: rdata = preset_q;
            TREG_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: rtl/sys_bridge.sv
// Data-side system bus: decodes M-stage accesses to data memory, two timers and
// the interrupt latch; handles sub-word stores/loads and address exceptions.
module sys_bridge
    import sys_bridge_pkg::*;
#(
    parameter int          DM_WORDS = DM_WORDS_DEF,
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF,
    parameter logic [31:0] IG_BASE  = IG_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Mem_Addr,
    input  logic [2:0]  Mem_SOp,
    input  logic [2:0]  Mem_LOp,
    input  logic [31:0] Mem_DI,
    input  logic        IntReq,
    input  logic        interrupt_in,
    output logic [31:0] Mem_DO,
    output logic [6:2]  Mem_EC,
    output logic [7:2]  HWInt
);

    localparam int DM_AW = $clog2(DM_WORDS);

    logic [31:0]      dm_q [DM_WORDS];
    logic [DM_AW-1:0] dm_idx;
    logic [31:0]      dm_rword, dm_wdata_d;
    logic             ig_q, ig_d;

    logic dm_hit, tc0_hit, tc1_hit, ig_hit, dev_hit, any_hit, count_hit;
    logic is_load, is_store, ld_word, ld_half, ld_bad, st_word, st_half, st_bad;
    logic ld_err, st_err, we_commit;
    logic [31:0] tc0_rdata, tc1_rdata, rword;
    logic        tc0_irq, tc1_irq;

    assign dm_idx    = Mem_Addr[DM_AW+1:2];
    assign dm_hit    = Mem_Addr < 32'(DM_WORDS * 4);
    assign tc0_hit   = in_timer(Mem_Addr, TC0_BASE);
    assign tc1_hit   = in_timer(Mem_Addr, TC1_BASE);
    assign ig_hit    = Mem_Addr[31:2] == IG_BASE[31:2];
    assign dev_hit   = tc0_hit | tc1_hit | ig_hit;
    assign any_hit   = dm_hit | dev_hit;
    assign count_hit = (tc0_hit | tc1_hit) & (Mem_Addr[3:2] == TREG_COUNT);

    assign is_load  = Mem_LOp != LOP_NONE;
    assign is_store = Mem_SOp != SOP_NONE;
    assign ld_word  = Mem_LOp == LOP_LW;
    assign ld_half  = (Mem_LOp == LOP_LH) | (Mem_LOp == LOP_LHU);
    assign ld_bad   = Mem_LOp > LOP_LBU;
    assign st_word  = Mem_SOp == SOP_SW;
    assign st_half  = Mem_SOp == SOP_SH;
    assign st_bad   = Mem_SOp > SOP_SB;

    // Exception detection: bad op, misalignment, unmapped, sub-word device access, COUNT store
    assign ld_err = ld_bad | (ld_word & (Mem_Addr[1:0] != 2'b00)) | (ld_half & Mem_Addr[0])
                  | !any_hit | (!ld_word & dev_hit);
    assign st_err = st_bad | (st_word & (Mem_Addr[1:0] != 2'b00)) | (st_half & Mem_Addr[0])
                  | !any_hit | (!st_word & dev_hit) | count_hit;

    assign Mem_EC    = (is_load & ld_err)  ? ERR_ADEL :
                       (is_store & st_err) ? ERR_ADES : ERR_NONE;
    assign we_commit = is_store & !st_err & !IntReq;

    timer_dev u_tc0 (
        .clk   (clk),
        .reset (reset),
        .we    (we_commit & tc0_hit),
        .addr  (Mem_Addr[3:2]),
        .wdata (Mem_DI),
        .rdata (tc0_rdata),
        .irq   (tc0_irq)
    );

    timer_dev u_tc1 (
        .clk   (clk),
        .reset (reset),
        .we    (we_commit & tc1_hit),
        .addr  (Mem_Addr[3:2]),
        .wdata (Mem_DI),
        .rdata (tc1_rdata),
        .irq   (tc1_irq)
    );

    assign dm_rword = dm_hit ? dm_q[dm_idx] : '0;

    // Store merge: place sub-word data into the lanes selected by the address
    always_comb begin
        logic [3:0]  be;
        logic [31:0] st_data, mask;
        be      = 4'b0000;
        st_data = Mem_DI;
        unique case (Mem_SOp)
            SOP_SW: be = 4'b1111;
            SOP_SH: begin
                be      = Mem_Addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{Mem_DI[15:0]}};
            end
            SOP_SB: begin
                be      = 4'b0001 << Mem_Addr[1:0];
                st_data = {4{Mem_DI[7:0]}};
            end
            default: be = 4'b0000;
        endcase
        mask       = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        dm_wdata_d = (dm_rword & ~mask) | (st_data & mask);
    end

    // Data memory: cleared on reset, one word written per committed store
    always_ff @(posedge clk) begin
        // NOTE: the memory is reset word-by-word because software relies on DM reading zero after reset; this forces a flop array rather than a RAM macro.
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= '0;
        end else if (we_commit & dm_hit) begin
            dm_q[dm_idx] <= dm_wdata_d;
        end
    end

    // Interrupt latch: a level on interrupt_in beats a same-cycle software clear
    always_comb begin
        ig_d = ig_q;
        if (we_commit & ig_hit) ig_d = 1'b0;
        if (interrupt_in)       ig_d = 1'b1;
    end

    // Interrupt latch register
    always_ff @(posedge clk) begin
        if (reset) ig_q <= 1'b0;
        else       ig_q <= ig_d;
    end

    // Read path: select the addressed word, then extract and extend the lane
    always_comb begin
        logic [7:0]  lbyte;
        logic [15:0] lhalf;
        rword = dm_hit  ? dm_rword  :
                tc0_hit ? tc0_rdata :
                tc1_hit ? tc1_rdata :
                ig_hit  ? {31'b0, ig_q} : '0;
        lbyte = rword[8*Mem_Addr[1:0] +: 8];
        lhalf = Mem_Addr[1] ? rword[31:16] : rword[15:0];
        unique case (Mem_LOp)
            LOP_LW:  Mem_DO = rword;
            LOP_LH:  Mem_DO = {{16{lhalf[15]}}, lhalf};
            LOP_LHU: Mem_DO = {16'b0, lhalf};
            LOP_LB:  Mem_DO = {{24{lbyte[7]}}, lbyte};
            LOP_LBU: Mem_DO = {24'b0, lbyte};
            default: Mem_DO = '0;
        endcase
        if (ld_err) Mem_DO = '0;
    end

    assign HWInt = {3'b000, ig_q, tc1_irq, tc0_irq};

endmodule

// File: tb/tb_sys_bridge.sv
// Directed bench for sys_bridge: memory access, exceptions, both timer modes,
// squashed stores and the interrupt latch.
module tb_sys_bridge;
    import sys_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Mem_Addr;
    logic [2:0]  Mem_SOp;
    logic [2:0]  Mem_LOp;
    logic [31:0] Mem_DI;
    logic        IntReq;
    logic        interrupt_in;
    logic [31:0] Mem_DO;
    logic [6:2]  Mem_EC;
    logic [7:2]  HWInt;

    int checks = 0;
    int errors = 0;

    sys_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .Mem_Addr     (Mem_Addr),
        .Mem_SOp      (Mem_SOp),
        .Mem_LOp      (Mem_LOp),
        .Mem_DI       (Mem_DI),
        .IntReq       (IntReq),
        .interrupt_in (interrupt_in),
        .Mem_DO       (Mem_DO),
        .Mem_EC       (Mem_EC),
        .HWInt        (HWInt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        Mem_Addr = '0;
        Mem_SOp  = SOP_NONE;
        Mem_LOp  = LOP_NONE;
        Mem_DI   = '0;
        IntReq   = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [2:0] sop, input logic [31:0] data);
        Mem_Addr = addr;
        Mem_SOp  = sop;
        Mem_LOp  = LOP_NONE;
        Mem_DI   = data;
        tick();
        bus_idle();
    endtask

    // Combinational load within the current cycle
    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [2:0] lop,
                            input logic [31:0] exp_do, input logic [4:0] exp_ec);
        Mem_Addr = addr;
        Mem_SOp  = SOP_NONE;
        Mem_LOp  = lop;
        #1;
        check({tag, ".do"}, Mem_DO, exp_do);
        check({tag, ".ec"}, {27'b0, Mem_EC}, {27'b0, exp_ec});
        bus_idle();
    endtask

    // Store exception check without committing (bus returned to idle before the edge)
    task automatic store_ec(input string tag, input logic [31:0] addr, input logic [2:0] sop,
                            input logic [4:0] exp_ec);
        Mem_Addr = addr;
        Mem_SOp  = sop;
        Mem_LOp  = LOP_NONE;
        Mem_DI   = 32'hA5A5_A5A5;
        #1;
        check(tag, {27'b0, Mem_EC}, {27'b0, exp_ec});
        bus_idle();
    endtask

    initial begin
        reset        = 1'b1;
        interrupt_in = 1'b0;
        bus_idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst.hwint", {26'b0, HWInt}, 32'h0);
        check("rst.ec", {27'b0, Mem_EC}, 32'h0);
        check("rst.do_idle", Mem_DO, 32'h0);
        load_chk("rst.dm", 32'h0000_0010, LOP_LW, 32'h0, ERR_NONE);
        load_chk("rst.tc0count", 32'h0000_7F08, LOP_LW, 32'h0, ERR_NONE);

        // Word store then sub-word loads with extension
        store(32'h0000_0010, SOP_SW, 32'h1234_5678);
        load_chk("ld.lw", 32'h0000_0010, LOP_LW, 32'h1234_5678, ERR_NONE);
        load_chk("ld.lb", 32'h0000_0011, LOP_LB, 32'h0000_0056, ERR_NONE);
        load_chk("ld.lh", 32'h0000_0012, LOP_LH, 32'h0000_1234, ERR_NONE);
        load_chk("ld.lbu", 32'h0000_0013, LOP_LBU, 32'h0000_0012, ERR_NONE);
        store(32'h0000_0015, SOP_SB, 32'hFFFF_FF80);
        store(32'h0000_0016, SOP_SH, 32'h0000_BEEF);
        load_chk("st.merge", 32'h0000_0014, LOP_LW, 32'hBEEF_8000, ERR_NONE);
        load_chk("ld.lb_neg", 32'h0000_0015, LOP_LB, 32'hFFFF_FF80, ERR_NONE);
        load_chk("ld.lh_neg", 32'h0000_0016, LOP_LH, 32'hFFFF_BEEF, ERR_NONE);
        load_chk("ld.lhu", 32'h0000_0016, LOP_LHU, 32'h0000_BEEF, ERR_NONE);

        // Address exceptions and range boundaries
        load_chk("err.lw_misalign", 32'h0000_0002, LOP_LW, 32'h0, ERR_ADEL);
        load_chk("err.lh_odd", 32'h0000_0011, LOP_LH, 32'h0, ERR_ADEL);
        load_chk("dm.last_word", 32'h0000_2FFC, LOP_LW, 32'h0, ERR_NONE);
        load_chk("err.tc_gap", 32'h0000_7F0C, LOP_LW, 32'h0, ERR_ADEL);
        load_chk("err.lh_timer", 32'h0000_7F00, LOP_LH, 32'h0, ERR_ADEL);
        store_ec("err.sh_oor", 32'h0000_3000, SOP_SH, ERR_ADES);
        Mem_Addr = 32'h0000_3000; Mem_SOp = SOP_SH; Mem_DI = 32'h0000_FFFF;
        tick();
        bus_idle();
        load_chk("err.sh_oor_nowrite", 32'h0000_0010, LOP_LW, 32'h1234_5678, ERR_NONE);
        store_ec("err.sb_timer", 32'h0000_7F04, SOP_SB, ERR_ADES);
        store_ec("err.sw_count", 32'h0000_7F08, SOP_SW, ERR_ADES);
        store_ec("err.sb_ig", 32'h0000_7F20, SOP_SB, ERR_ADES);

        // Timer0 one-shot: PRESET=3, CTRL=en|IM
        store(32'h0000_7F04, SOP_SW, 32'd3);
        store(32'h0000_7F00, SOP_SW, 32'h9);
        tick();   // LOAD
        tick();
        load_chk("tc0.count3", 32'h0000_7F08, LOP_LW, 32'd3, ERR_NONE);
        tick();
        load_chk("tc0.count2", 32'h0000_7F08, LOP_LW, 32'd2, ERR_NONE);
        tick();
        load_chk("tc0.count1", 32'h0000_7F08, LOP_LW, 32'd1, ERR_NONE);
        tick();
        load_chk("tc0.count0", 32'h0000_7F08, LOP_LW, 32'd0, ERR_NONE);
        check("tc0.irq_not_yet", {26'b0, HWInt}, 32'h0);
        tick();
        check("tc0.irq_set", {26'b0, HWInt}, 32'h1);
        load_chk("tc0.en_cleared", 32'h0000_7F00, LOP_LW, 32'h8, ERR_NONE);
        tick();
        tick();
        check("tc0.irq_held", {26'b0, HWInt}, 32'h1);
        store(32'h0000_7F00, SOP_SW, 32'h0);
        check("tc0.irq_cleared", {26'b0, HWInt}, 32'h0);

        // Timer1 auto-reload: PRESET=2 gives a 1-cycle pulse every 4 cycles
        store(32'h0000_7F14, SOP_SW, 32'd2);
        store(32'h0000_7F10, SOP_SW, 32'hB);
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("tc1.pulse_k%0d", k), {26'b0, HWInt},
                  ((k >= 5) && ((k - 5) % 4 == 0)) ? 32'h2 : 32'h0);
        end
        tick();   // mid-count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("tc1.rst_hwint", {26'b0, HWInt}, 32'h0);
        load_chk("tc1.rst_count", 32'h0000_7F18, LOP_LW, 32'h0, ERR_NONE);
        load_chk("rst.dm_cleared", 32'h0000_0010, LOP_LW, 32'h0, ERR_NONE);

        // Store squashed by IntReq
        Mem_Addr = 32'h0000_0020; Mem_SOp = SOP_SW; Mem_DI = 32'hDEAD_BEEF; IntReq = 1'b1;
        #1;
        check("squash.ec", {27'b0, Mem_EC}, 32'h0);
        tick();
        bus_idle();
        load_chk("squash.unchanged", 32'h0000_0020, LOP_LW, 32'h0, ERR_NONE);
        store(32'h0000_0020, SOP_SW, 32'hDEAD_BEEF);
        load_chk("squash.then_commit", 32'h0000_0020, LOP_LW, 32'hDEAD_BEEF, ERR_NONE);

        // Interrupt latch
        interrupt_in = 1'b1;
        tick();
        interrupt_in = 1'b0;
        check("ig.set", {26'b0, HWInt}, 32'h4);
        tick();
        check("ig.held", {26'b0, HWInt}, 32'h4);
        load_chk("ig.read", 32'h0000_7F20, LOP_LW, 32'h1, ERR_NONE);
        store(32'h0000_7F20, SOP_SW, 32'h0);
        check("ig.cleared", {26'b0, HWInt}, 32'h0);
        interrupt_in = 1'b1;
        store(32'h0000_7F20, SOP_SW, 32'h0);
        interrupt_in = 1'b0;
        check("ig.set_wins", {26'b0, HWInt}, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
